// File: rtl/qam_pkg.sv
// Shared QAM definitions: mode codes, bits per symbol, Gray levels and the constellation map.
// Also used by the receiver-side model, so the 16QAM constellation lives here and only here.
package qam_pkg;

    localparam logic MOD_QPSK  = 1'b0;
    localparam logic MOD_16QAM = 1'b1;

    localparam int BITS_QPSK  = 2;
    localparam int BITS_16QAM = 4;

    localparam logic signed [2:0] LVL_M3 = -3'sd3;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_P3 = 3'sd3;

    typedef struct packed {
        logic signed [2:0] i;
        logic signed [2:0] q;
    } iq_t;

    function automatic logic signed [2:0] gray_level(input logic [1:0] g);
        case (g)
            2'b00:   gray_level = LVL_M3;
            2'b01:   gray_level = LVL_M1;
            2'b11:   gray_level = LVL_P1;
            default: gray_level = LVL_P3;
        endcase
    endfunction

    // QPSK only looks at word[1:0]; the upper bits are don't-care there.
    function automatic iq_t gray_map(input logic mode, input logic [3:0] word);
        iq_t r;
        if (mode == MOD_16QAM) begin
            r.i = gray_level(word[3:2]);
            r.q = gray_level(word[1:0]);
        end else begin
            r.i = word[1] ? LVL_P3 : LVL_M3;
            r.q = word[0] ? LVL_P3 : LVL_M3;
        end
        return r;
    endfunction

endpackage

// File: rtl/qam_gray_map.sv
// Combinational Gray mapper: {mode, word} to sign-extended I/Q levels.
// Latency: none (pure combinational).
// Backpressure: none; follows its inputs every cycle.
module qam_gray_map
    import qam_pkg::*;
#(
    parameter int LVL_W = 4
) (
    input  logic                    mode,
    input  logic [3:0]              word,
    output logic signed [LVL_W-1:0] i,
    output logic signed [LVL_W-1:0] q
);

    iq_t               m;
    logic signed [2:0] li;
    logic signed [2:0] lq;

    assign m  = gray_map(mode, word);
    assign li = m.i;
    assign lq = m.q;
    assign i  = LVL_W'(li);
    assign q  = LVL_W'(lq);

endmodule

// File: rtl/qam_symbol_mapper.sv
// Packs serial bits into QPSK/16QAM symbols and releases one mapped symbol per sym_tick.
// Latency: one clk_in cycle from sym_tick to i_out/q_out/sym_valid (or underflow).
// Backpressure: bit_ready drops only for the completing bit while the one-symbol buffer is full.
module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int LVL_W = 4
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    mod_type,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic                    sym_tick,
    output logic signed [LVL_W-1:0] i_out,
    output logic signed [LVL_W-1:0] q_out,
    output logic                    sym_valid,
    output logic                    underflow
);

    localparam logic [1:0] LAST_QPSK  = 2'(BITS_QPSK - 1);
    localparam logic [1:0] LAST_16QAM = 2'(BITS_16QAM - 1);

    logic [1:0] cnt;
    logic [3:0] shreg;
    logic       mode_lat;
    logic [3:0] hold_word;
    logic       hold_mode;
    logic       hold_full;

    logic       cur_mode;
    logic       last;
    logic       xfer;
    logic       complete;
    logic [3:0] next_word;

    logic signed [LVL_W-1:0] map_i;
    logic signed [LVL_W-1:0] map_q;

    // The first bit of a symbol decides its mode; later bits use the latched copy.
    assign cur_mode  = (cnt == 2'd0) ? mod_type : mode_lat;
    assign last      = (cnt == ((cur_mode == MOD_16QAM) ? LAST_16QAM : LAST_QPSK));
    assign bit_ready = !(last && hold_full && !sym_tick);
    assign xfer      = bit_valid && bit_ready;
    assign complete  = xfer && last;
    assign next_word = {shreg[2:0], bit_in};

    qam_gray_map #(.LVL_W(LVL_W)) u_map (
        .mode (hold_mode),
        .word (hold_word),
        .i    (map_i),
        .q    (map_q)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt       <= '0;
            shreg     <= '0;
            mode_lat  <= MOD_QPSK;
            hold_word <= '0;
            hold_mode <= MOD_QPSK;
            hold_full <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sym_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            underflow <= 1'b0;

            if (xfer) begin
                if (cnt == 2'd0) begin
                    mode_lat <= mod_type;
                end
                if (complete) begin
                    cnt       <= '0;
                    shreg     <= '0;
                    hold_word <= next_word;
                    hold_mode <= cur_mode;
                end else begin
                    cnt   <= cnt + 2'd1;
                    shreg <= next_word;
                end
            end

            // Old held symbol is read out on the same edge a new one may overwrite it.
            if (sym_tick) begin
                if (hold_full) begin
                    i_out     <= map_i;
                    q_out     <= map_q;
                    sym_valid <= 1'b1;
                end else begin
                    i_out     <= '0;
                    q_out     <= '0;
                    underflow <= 1'b1;
                end
            end

            if (complete) begin
                hold_full <= 1'b1;
            end else if (sym_tick) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper: Gray-map table sweep plus backpressure, collision,
// mode-latching and reset corner sequences.
module tb_qam_symbol_mapper;

    localparam int LVL_W = 4;

    logic                    clk_in = 1'b0;
    logic                    rst = 1'b1;
    logic                    mod_type = 1'b0;
    logic                    bit_in = 1'b0;
    logic                    bit_valid = 1'b0;
    logic                    bit_ready;
    logic                    sym_tick = 1'b0;
    logic signed [LVL_W-1:0] i_out;
    logic signed [LVL_W-1:0] q_out;
    logic                    sym_valid;
    logic                    underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       mode;
        logic [3:0] word;
        int         ei;
        int         eq;
    } vec_t;

    vec_t vecs[20];

    qam_symbol_mapper #(.LVL_W(LVL_W)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .mod_type  (mod_type),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sym_tick  (sym_tick),
        .i_out     (i_out),
        .q_out     (q_out),
        .sym_valid (sym_valid),
        .underflow (underflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic m);
        int n;
        n = 0;
        bit_in    = b;
        mod_type  = m;
        bit_valid = 1'b1;
        #1;
        while (!bit_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("bit_ready_timeout", 0, 1);
        step();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic m, input logic [3:0] w);
        int k;
        k = (m == 1'b1) ? 4 : 2;
        for (int b = k - 1; b >= 0; b--) send_bit(w[b], m);
    endtask

    task automatic tick();
        sym_tick = 1'b1;
        step();
        sym_tick = 1'b0;
    endtask

    task automatic check_sym(input string name, input int ei, input int eq);
        check({name, "_valid"}, int'(sym_valid), 1);
        check({name, "_i"}, int'(i_out), ei);
        check({name, "_q"}, int'(q_out), eq);
        check({name, "_uflow"}, int'(underflow), 0);
    endtask

    task automatic check_uflow(input string name);
        check({name, "_uflow"}, int'(underflow), 1);
        check({name, "_valid"}, int'(sym_valid), 0);
        check({name, "_i"}, int'(i_out), 0);
        check({name, "_q"}, int'(q_out), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] seq;

    initial begin
        vecs[0]  = '{1'b1, 4'h0, -3, -3};
        vecs[1]  = '{1'b1, 4'h1, -3, -1};
        vecs[2]  = '{1'b1, 4'h2, -3,  3};
        vecs[3]  = '{1'b1, 4'h3, -3,  1};
        vecs[4]  = '{1'b1, 4'h4, -1, -3};
        vecs[5]  = '{1'b1, 4'h5, -1, -1};
        vecs[6]  = '{1'b1, 4'h6, -1,  3};
        vecs[7]  = '{1'b1, 4'h7, -1,  1};
        vecs[8]  = '{1'b1, 4'h8,  3, -3};
        vecs[9]  = '{1'b1, 4'h9,  3, -1};
        vecs[10] = '{1'b1, 4'hA,  3,  3};
        vecs[11] = '{1'b1, 4'hB,  3,  1};
        vecs[12] = '{1'b1, 4'hC,  1, -3};
        vecs[13] = '{1'b1, 4'hD,  1, -1};
        vecs[14] = '{1'b1, 4'hE,  1,  3};
        vecs[15] = '{1'b1, 4'hF,  1,  1};
        vecs[16] = '{1'b0, 4'h0, -3, -3};
        vecs[17] = '{1'b0, 4'h1, -3,  3};
        vecs[18] = '{1'b0, 4'h2,  3, -3};
        vecs[19] = '{1'b0, 4'h3,  3,  3};

        do_reset();
        check("rst_i", int'(i_out), 0);
        check("rst_q", int'(q_out), 0);
        check("rst_valid", int'(sym_valid), 0);
        check("rst_uflow", int'(underflow), 0);
        check("rst_ready", int'(bit_ready), 1);

        // QPSK 1,0 then one tick: +3/-3, valid for exactly one cycle.
        send_word(1'b0, 4'b0010);
        check("qpsk_pre_valid", int'(sym_valid), 0);
        tick();
        check_sym("qpsk10", 3, -3);
        step();
        check("qpsk10_pulse", int'(sym_valid), 0);
        check("qpsk10_hold_i", int'(i_out), 3);
        check("qpsk10_hold_q", int'(q_out), -3);

        // Tick with nothing buffered.
        tick();
        check_uflow("uflow");
        step();
        check("uflow_pulse", int'(underflow), 0);

        for (int v = 0; v < 20; v++) begin
            send_word(vecs[v].mode, vecs[v].word);
            tick();
            check_sym($sformatf("vec%0d", v), vecs[v].ei, vecs[v].eq);
        end

        // Backpressure: 16QAM words 1001 and 0110 streamed with no tick.
        seq = 8'b1001_0110;
        mod_type = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bit_in    = seq[7-b];
            bit_valid = 1'b1;
            #1;
            check($sformatf("bp_ready%0d", b), int'(bit_ready), (b < 7) ? 1 : 0);
            step();
        end
        check("bp_still_blocked", int'(bit_ready), 0);
        sym_tick = 1'b1;
        #1;
        check("bp_ready_on_tick", int'(bit_ready), 1);
        step();
        sym_tick  = 1'b0;
        bit_valid = 1'b0;
        check_sym("bp_sym1", 3, -1);
        tick();
        check_sym("bp_sym2", -1, 3);
        tick();
        check_uflow("bp_drained");

        // Completion and tick on the same edge (QPSK 11 then 00).
        send_word(1'b0, 4'b0011);
        send_bit(1'b0, 1'b0);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        sym_tick  = 1'b1;
        #1;
        check("coll_ready", int'(bit_ready), 1);
        step();
        bit_valid = 1'b0;
        sym_tick  = 1'b0;
        check_sym("coll_sym11", 3, 3);
        tick();
        check_sym("coll_sym00", -3, -3);
        tick();
        check_uflow("coll_drained");

        // Mode flips to QPSK after the first bit of a 16QAM symbol (word 1110).
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick();
        check_sym("mode_latch", 1, 3);
        send_word(1'b0, 4'b0001);
        tick();
        check_sym("mode_next", -3, 3);

        // Reset mid-symbol with a symbol held and nonzero outputs.
        send_word(1'b0, 4'b0011);
        send_bit(1'b1, 1'b1);
        do_reset();
        check("mrst_i", int'(i_out), 0);
        check("mrst_q", int'(q_out), 0);
        check("mrst_valid", int'(sym_valid), 0);
        check("mrst_ready", int'(bit_ready), 1);
        tick();
        check_uflow("mrst_hold_gone");
        send_word(1'b0, 4'b0010);
        tick();
        check_sym("mrst_fresh", 3, -3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
